uart_byte_streamer: RTL

Serializes the byte stream produced by the number byte repeater onto a UART TX line (8N1, LSB first). It pulls bytes with a single-cycle request pulse, so it sits directly downstream of the repeater, whose byte output and valid feed `data_in`/`valid_in` and whose request input is driven by `request_next_byte_out`. It counts transmitted bytes and flags the end of each full number so the top level can sequence the next operand.

---
 rtl/uart_pkg.sv | 16 +
 rtl/evt_counter.sv | 23 ++
 rtl/uart_byte_streamer.sv | 114 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and baud timing helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    // Integer clock cycles per line bit; RX and TX must agree on this value.
    function automatic int cycles_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/evt_counter.sv
// Wrapping event counter: advances on evt_in, returns to zero after MAX_COUNT-1.
module evt_counter #(
    parameter int MAX_COUNT = 4,
    parameter int WIDTH     = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             evt_in,
    output logic [WIDTH-1:0] count_out
);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_out <= '0;
        end else if (evt_in) begin
            if (count_out == WIDTH'(MAX_COUNT - 1))
                count_out <= '0;
            else
                count_out <= count_out + 1'b1;
        end
    end

endmodule

// File: rtl/uart_byte_streamer.sv
// 8N1 UART transmitter that pulls bytes from an upstream repeater and flags
// the final stop bit of every BYTES_PER_NUM-byte number.
module uart_byte_streamer
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ  = 100_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int BITS_IN_NUM = 4096
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       request_next_byte_out,
    output logic       tx_out,
    output logic       busy_out,
    output logic       num_done_out
);

    localparam int CYCLES_PER_BIT = cycles_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int BYTES_PER_NUM  = BITS_IN_NUM / 8;
    localparam int BAUD_W         = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam int BYTE_W         = (BYTES_PER_NUM > 1) ? $clog2(BYTES_PER_NUM) : 1;

    uart_tx_state_t    state;
    logic [7:0]        shift_reg;
    logic [2:0]        bit_idx;
    logic              tx_reg;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BYTE_W-1:0] byte_cnt;
    logic              accept;
    logic              baud_last;
    logic              stop_last;

    assign accept    = !rst_in && (state == IDLE) && valid_in;
    assign baud_last = (baud_cnt == BAUD_W'(CYCLES_PER_BIT - 1));
    assign stop_last = (state == STOP) && baud_last;

    // Restarting on acceptance aligns every bit period to the frame start.
    evt_counter #(
        .MAX_COUNT(CYCLES_PER_BIT),
        .WIDTH    (BAUD_W)
    ) u_baud_cnt (
        .clk_in   (clk_in),
        .rst_in   (rst_in || accept),
        .evt_in   (state != IDLE),
        .count_out(baud_cnt)
    );

    evt_counter #(
        .MAX_COUNT(BYTES_PER_NUM),
        .WIDTH    (BYTE_W)
    ) u_byte_cnt (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .evt_in   (stop_last),
        .count_out(byte_cnt)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state   <= IDLE;
            bit_idx <= '0;
            tx_reg  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        state   <= START;
                        bit_idx <= '0;
                        tx_reg  <= 1'b0;
                    end
                end
                START: begin
                    if (baud_last) begin
                        state  <= DATA;
                        tx_reg <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        if (bit_idx == 3'd7) begin
                            state  <= STOP;
                            tx_reg <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_reg  <= shift_reg[1];
                        end
                    end
                end
                STOP: begin
                    if (baud_last)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Payload only; its contents are irrelevant until the next acceptance.
    always_ff @(posedge clk_in) begin
        if (accept)
            shift_reg <= data_in;
        else if ((state == DATA) && baud_last)
            shift_reg <= {1'b0, shift_reg[7:1]};
    end

    assign request_next_byte_out = accept;
    assign tx_out                = tx_reg;
    assign busy_out              = (state != IDLE);
    assign num_done_out          = !rst_in && stop_last
                                   && (byte_cnt == BYTE_W'(BYTES_PER_NUM - 1));

endmodule
